bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the serial pattern detector. The block accepts DATA_W-bit words over a valid/ready handshake and emits them one bit per clock on `d_o`/`valid_o`. Those two outputs connect directly to the detector's `d_i`/`valid_i`. A one-entry holding register lets words stream back-to-back with no idle cycles on the serial side.

## Interface
- DATA_W, 8: word width in bits, ≥2.
- MSB_FIRST, 1: 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- data_i  input  DATA_W  parallel word.
- data_valid_i  input  1  `data_i` is valid.
- data_ready_o  output  1  block can take a word; transfer occurs when `data_valid_i & data_ready_o` at a rising edge.
- d_o  output  1  serial bit; goes to the detector's `d_i`.
- valid_o  output  1  `d_o` is valid; goes to the detector's `valid_i`.
- word_done_o  output  1  high during the cycle the last bit of a word is on `d_o`.
- busy_o  output  1  shifter active or holding register full.

## Operation
- Storage:
  - SHIFT: DATA_W-bit shift register.
  - bit counter: 0..DATA_W-1, width $clog2(DATA_W).
  - HOLD: DATA_W-bit holding register with a `hold_full` flag.
- States:
  - IDLE: shifter empty.
  - SEND: a word is shifting out.
- `d_o` is the current output end of SHIFT: bit DATA_W-1 if MSB_FIRST, else bit 0. Shift direction matches.
- `data_ready_o = rst & !hold_full`. It is low while reset is asserted.
- Each accepted word goes to exactly one place:
  - Directly into SHIFT if state is IDLE, or if state is SEND with counter = DATA_W-1 and `hold_full` = 0. Counter resets to 0; state becomes SEND.
  - Otherwise into HOLD; `hold_full` sets to 1.
- In SEND with counter < DATA_W-1: shift one position and increment the counter.
- In SEND with counter = DATA_W-1 (last bit):
  - HOLD full: load SHIFT from HOLD, clear `hold_full`, counter to 0, stay in SEND.
  - Else, word accepted this cycle: load it directly, stay in SEND.
  - Else: go to IDLE.
- While `hold_full` = 1, `data_ready_o` = 0, so acceptance and a HOLD→SHIFT transfer never coincide.
- Outputs in IDLE: `valid_o` = 0, `d_o` = 0, `word_done_o` = 0.
- `word_done_o = (state==SEND) & (counter==DATA_W-1)`.
- `busy_o = (state==SEND) | hold_full`.
- Words are never dropped or reordered. `data_i` is ignored unless a transfer occurs.

## Timing
- Reset (rst=0 at an edge): state IDLE, counter 0, `hold_full` 0, SHIFT and HOLD cleared. Outputs: `d_o` 0, `valid_o` 0, `word_done_o` 0, `busy_o` 0. `data_ready_o` is 0 during reset and 1 in the first cycle after deassertion.
- Reset mid-word discards the in-flight word and any held word. `valid_o` is 0 in the cycle after the reset edge.
- Latency: a word accepted at edge k drives its first bit on `d_o` with `valid_o` = 1 in cycle k+1 (after edge k). Its last bit appears in cycle k+DATA_W.
- Sustained throughput: one word per DATA_W cycles. With continuous input, `valid_o` stays high without gaps.
- Back-to-back from IDLE with `data_valid_i` held high:
  - word 1 accepted at edge 0 into SHIFT;
  - word 2 accepted at edge 1 into HOLD;
  - `data_ready_o` is low from cycle 2 until HOLD drains at edge DATA_W;
  - `data_ready_o` is high again in cycle DATA_W+1.
- `data_valid_i` deasserted mid-stream: after the last queued bit, `valid_o` drops in the next cycle. There is no partial word.

## Test plan
- Reset then a single word 8'hB6 (MSB_FIRST=1): `d_o` = 1,0,1,1,0,1,1,0 in cycles 1..8 after acceptance; `valid_o` high exactly 8 cycles; `word_done_o` high only in cycle 8; `busy_o` low from cycle 9.
- Same word with MSB_FIRST=0: `d_o` = 0,1,1,0,1,1,0,1.
- Three words 8'hFF, 8'h00, 8'hA5 with `data_valid_i` held high: 24 contiguous `valid_o` cycles with correct bits; `data_ready_o` follows the schedule in Timing; all three words emitted in order.
- Reset asserted at the 4th bit of 8'hF0 with HOLD full: the next cycle shows `valid_o` 0, `busy_o` 0, and `data_ready_o` 0 while reset is held. A word accepted after reset emits correctly from cycle 1.
- Integration with the pattern detector: 100 random words feed the detector. The detector's pulse count must equal a bench reference model run on the same bit stream, including matches that span word boundaries.
- Gapped input (one word every 12 cycles): `valid_o` runs 8 cycles high then 4 low, with `d_o` = 0 during the gaps.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: DATA_W-bit words in over valid/ready,
// one bit per clock out, with a one-word holding register for streaming.
module bit_serializer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic              d_o,
    output logic              valid_o,
    output logic              word_done_o,
    output logic              busy_o
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_full;

    state_t            w_state_nx;
    logic [CW-1:0]     w_cnt_nx;
    logic [DATA_W-1:0] w_shift_nx;
    logic [DATA_W-1:0] w_hold_nx;
    logic              w_hold_full_nx;
    logic [DATA_W-1:0] w_shifted;
    logic              w_out_bit;
    logic              w_accept;
    logic              w_last;

    assign data_ready_o = rst & ~r_hold_full;
    assign w_accept     = data_valid_i & data_ready_o;
    assign w_last       = (r_state == S_SEND) && (r_cnt == LAST);
    assign w_out_bit    = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];

    assign valid_o      = (r_state == S_SEND);
    assign d_o          = (r_state == S_SEND) & w_out_bit;
    assign word_done_o  = w_last;
    assign busy_o       = (r_state == S_SEND) | r_hold_full;

    // Shift toward the output end so the next bit lands on d_o.
    always_comb begin
        w_shifted = r_shift;
        if (MSB_FIRST) begin
            w_shifted = {r_shift[DATA_W-2:0], 1'b0};
        end else begin
            w_shifted = {1'b0, r_shift[DATA_W-1:1]};
        end
    end

    // Next-state: route each accepted word to SHIFT or HOLD, advance bits.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_shift_nx     = r_shift;
        w_hold_nx      = r_hold;
        w_hold_full_nx = r_hold_full;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shift_nx = data_i;
                    w_cnt_nx   = '0;
                    w_state_nx = S_SEND;
                end
            end
            S_SEND: begin
                if (!w_last) begin
                    w_shift_nx = w_shifted;
                    w_cnt_nx   = r_cnt + 1'b1;
                    if (w_accept) begin
                        w_hold_nx      = data_i;
                        w_hold_full_nx = 1'b1;
                    end
                end else if (r_hold_full) begin
                    w_shift_nx     = r_hold;
                    w_hold_full_nx = 1'b0;
                    w_cnt_nx       = '0;
                end else if (w_accept) begin
                    w_shift_nx = data_i;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_shift     <= w_shift_nx;
            r_hold      <= w_hold_nx;
            r_hold_full <= w_hold_full_nx;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: both bit orders against a bit-queue model,
// plus literal expectations for the directed scenarios.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_i;
    logic         data_valid_i;

    logic dr_m, d_m, v_m, wd_m, b_m;
    logic dr_l, d_l, v_l, wd_l, b_l;

    int checks = 0;
    int errors = 0;

    bit q_m[$];
    bit q_l[$];
    int n_acc = 0;

    bit         rec_on = 0;
    logic [7:0] rec_m, rec_l;
    int         vcnt, dcnt, run, maxrun;

    bit         pat_on = 0;
    logic [3:0] win_d, win_e;
    int         nd, ne, pat_d, pat_e;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .data_i(data_i),
        .data_valid_i(data_valid_i), .data_ready_o(dr_m),
        .d_o(d_m), .valid_o(v_m), .word_done_o(wd_m), .busy_o(b_m)
    );

    bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data_i(data_i),
        .data_valid_i(data_valid_i), .data_ready_o(dr_l),
        .d_o(d_l), .valid_o(v_l), .word_done_o(wd_l), .busy_o(b_l)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: pending bits in send order; a word occupies W bits.
    always @(posedge clk) begin
        bit acc;
        if (!rst) begin
            q_m.delete();
            q_l.delete();
        end else begin
            acc = data_valid_i && (q_m.size() <= W);
            if (q_m.size() > 0) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    q_m.push_back(data_i[W-1-i]);
                    q_l.push_back(data_i[i]);
                end
                n_acc++;
            end
        end
    end

    // Per-cycle comparison of every output of both instances.
    always @(negedge clk) begin
        int  n;
        bit  er, ed_m, ed_l;
        n    = q_m.size();
        er   = rst && (n <= W);
        ed_m = (n > 0) ? q_m[0] : 1'b0;
        ed_l = (n > 0) ? q_l[0] : 1'b0;
        check("ready_msb", dr_m, er);
        check("ready_lsb", dr_l, er);
        check("valid_msb", v_m, n > 0);
        check("valid_lsb", v_l, n > 0);
        check("d_msb", d_m, ed_m);
        check("d_lsb", d_l, ed_l);
        check("done_msb", wd_m, (n > 0) && (n % W == 1));
        check("done_lsb", wd_l, (n > 0) && (n % W == 1));
        check("busy_msb", b_m, n > 0);
        check("busy_lsb", b_l, n > 0);
        if (rec_on) begin
            if (v_m) rec_m = {rec_m[6:0], d_m};
            if (v_l) rec_l = {rec_l[6:0], d_l};
            if (v_m) vcnt++;
            if (wd_m) dcnt++;
            run = v_m ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        if (pat_on) begin
            if (v_m) begin
                win_d = {win_d[2:0], d_m};
                nd++;
                if (nd >= 4 && win_d == 4'b1011) pat_d++;
            end
            if (n > 0) begin
                win_e = {win_e[2:0], ed_m};
                ne++;
                if (ne >= 4 && win_e == 4'b1011) pat_e++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rec_clear();
        rec_m = '0; rec_l = '0;
        vcnt = 0; dcnt = 0; run = 0; maxrun = 0;
    endtask

    task automatic drain(input string name);
        int k;
        data_valid_i = 1'b0;
        k = 0;
        while (q_m.size() > 0 && k < 200) begin
            tick();
            k++;
        end
        if (q_m.size() > 0) begin
            errors++;
            $display("FAIL %s: drain timeout, %0d bits left expected 0", name, q_m.size());
        end
        repeat (3) tick();
    endtask

    task automatic send_stream(input logic [7:0] w0, input logic [7:0] w1,
                               input logic [7:0] w2, input int cnt);
        logic [7:0] ws [3];
        int base, k;
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        base = n_acc;
        k = 0;
        while (n_acc - base < cnt && k < 100) begin
            data_valid_i = 1'b1;
            data_i = ws[n_acc - base];
            tick();
            k++;
        end
        if (n_acc - base < cnt) begin
            errors++;
            $display("FAIL stream_accept: got %0d words expected %0d", n_acc - base, cnt);
        end
        data_valid_i = 1'b0;
    endtask

    initial begin
        int base, k;
        rst = 1'b0;
        data_valid_i = 1'b0;
        data_i = '0;
        rec_clear();
        repeat (2) tick();
        check("rst_busy", b_m, 1'b0);
        check("rst_ready", dr_m, 1'b0);
        rst = 1'b1;
        #1;
        check("ready_after_rst", dr_m, 1'b1);

        rec_clear();
        rec_on = 1;
        send_stream(8'hB6, 8'h00, 8'h00, 1);
        drain("single");
        rec_on = 0;
        check_int("b6_msb_bits", int'(rec_m), 8'b10110110);
        check_int("b6_lsb_bits", int'(rec_l), 8'b01101101);
        check_int("b6_valid_cycles", vcnt, 8);
        check_int("b6_done_cycles", dcnt, 1);

        rec_clear();
        rec_on = 1;
        send_stream(8'hFF, 8'h00, 8'hA5, 3);
        drain("three");
        rec_on = 0;
        check_int("three_run", maxrun, 24);
        check_int("three_valid", vcnt, 24);
        check_int("three_done", dcnt, 3);
        check_int("three_last_msb", int'(rec_m), 8'hA5);

        send_stream(8'hF0, 8'h3C, 8'h00, 2);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("midrst_valid", v_m, 1'b0);
        check("midrst_busy", b_m, 1'b0);
        check("midrst_ready", dr_m, 1'b0);
        tick();
        rst = 1'b1;
        rec_clear();
        rec_on = 1;
        send_stream(8'h96, 8'h00, 8'h00, 1);
        drain("after_rst");
        rec_on = 0;
        check_int("after_rst_bits", int'(rec_m), 8'h96);

        rec_clear();
        rec_on = 1;
        for (int w = 0; w < 4; w++) begin
            data_i = 8'(8'h5A + w * 17);
            data_valid_i = 1'b1;
            tick();
            data_valid_i = 1'b0;
            repeat (11) tick();
        end
        drain("gapped");
        rec_on = 0;
        check_int("gap_run", maxrun, 8);
        check_int("gap_valid", vcnt, 32);

        win_d = '0; win_e = '0;
        nd = 0; ne = 0; pat_d = 0; pat_e = 0;
        pat_on = 1;
        base = n_acc;
        k = 0;
        while (n_acc - base < 100 && k < 3000) begin
            data_valid_i = ($urandom_range(0, 3) != 0);
            data_i = 8'($urandom);
            tick();
            k++;
        end
        if (n_acc - base < 100) begin
            errors++;
            $display("FAIL random_accept: got %0d words expected 100", n_acc - base);
        end
        drain("random");
        pat_on = 0;
        check_int("pattern_count", pat_d, pat_e);
        check_int("random_bits", nd, 800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
